// File: rtl/ring_access_sequencer.sv
// Request front-end for the shift-register ring memory controller: converts absolute
// slot requests into relative step counts. Optional feature macro: ZERO_STEP_BYPASS_EN.
module ring_access_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RING_SLOTS    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_error,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     src_start,
  output logic                     src_write,
  output logic [ADDRESS_WIDTH-1:0] src_num_steps,
  output logic [DATA_WIDTH-1:0]    src_value,
  input  logic                     src_last_step,
  input  logic [DATA_WIDTH-1:0]    src_buffer
);

  localparam logic [ADDRESS_WIDTH:0]   Slots   = (ADDRESS_WIDTH + 1)'(RING_SLOTS);
  localparam logic [ADDRESS_WIDTH-1:0] SlotsLo = Slots[ADDRESS_WIDTH-1:0];

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] cursor_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;

  logic                     accept;
  logic                     in_range;
  logic [ADDRESS_WIDTH:0]   diff;
  logic [ADDRESS_WIDTH-1:0] steps;

  // Modular distance from the cursor; low bits wrap naturally, so only the
  // borrow decides whether the ring size must be added back.
  always_comb begin
    diff     = {1'b0, req_addr} - {1'b0, cursor_q};
    steps    = diff[ADDRESS_WIDTH] ? (diff[ADDRESS_WIDTH-1:0] + SlotsLo)
                                   : diff[ADDRESS_WIDTH-1:0];
    in_range = ({1'b0, req_addr} < Slots);
  end

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cursor_q      <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_rdata     <= '0;
      src_start     <= 1'b0;
      src_write     <= 1'b0;
      src_num_steps <= '0;
      src_value     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!in_range) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
`ifdef ZERO_STEP_BYPASS_EN
            end else if (!req_write && (steps == '0)) begin
              // Buffer already holds the requested slot.
              rsp_valid <= 1'b1;
              rsp_rdata <= src_buffer;
`endif
            end else begin
              req_ready     <= 1'b0;
              write_q       <= req_write;
              addr_q        <= req_addr;
              src_start     <= 1'b1;
              src_write     <= req_write;
              src_num_steps <= steps;
              src_value     <= req_wdata;
              state_q       <= StIssue;
            end
          end
        end
        // lastStep may still be high from a previous access, so it is not looked at here.
        StIssue: state_q <= StWait;
        StWait: begin
          if (src_last_step) begin
            src_start <= 1'b0;
            src_write <= 1'b0;
            state_q   <= StDrain;
          end
        end
        StDrain: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= write_q ? src_value : src_buffer;
          cursor_q  <= addr_q;
          req_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_access_sequencer.sv
// Bench for ring_access_sequencer (RING_SLOTS=12): directed steps then random requests,
// checked against a modular-arithmetic cursor model and a mock controller.
module tb_ring_access_sequencer;

  localparam int N = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_error;
  logic [7:0] rsp_rdata;
  logic       src_start;
  logic       src_write;
  logic [3:0] src_num_steps;
  logic [7:0] src_value;
  logic       src_last_step;
  logic [7:0] src_buffer;

  int total = 0;
  int bad   = 0;
  int cursor = 0;

  always #5 clk = ~clk;

  ring_access_sequencer #(
    .ADDRESS_WIDTH(4),
    .DATA_WIDTH   (8),
    .RING_SLOTS   (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_error    (rsp_error),
    .rsp_rdata    (rsp_rdata),
    .src_start    (src_start),
    .src_write    (src_write),
    .src_num_steps(src_num_steps),
    .src_value    (src_value),
    .src_last_step(src_last_step),
    .src_buffer   (src_buffer)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Starts and ends at a negedge with the sequencer idle. delay = WAIT cycles before lastStep.
  task automatic run_req(input bit wr, input int addr, input logic [7:0] wd, input int delay,
                         input bit hold);
    logic [7:0] bufv;
    int         steps;
    chk("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = 4'(addr);
    req_wdata  = wd;
    bufv       = 8'($urandom);
    src_buffer = bufv;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    // Scramble request fields: they must only matter at accept.
    req_write = 1'($urandom);
    req_addr  = 4'($urandom);
    req_wdata = 8'($urandom);
    if (addr >= N) begin
      @(negedge clk);
      chk("err_valid", rsp_valid, 1);
      chk("err_flag", rsp_error, 1);
      chk("err_rdata", rsp_rdata, 0);
      chk("err_start", src_start, 0);
      chk("err_ready", req_ready, 1);
      return;
    end
    steps = (addr - cursor + N) % N;
`ifdef ZERO_STEP_BYPASS_EN
    if (!wr && steps == 0) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_error", rsp_error, 0);
      chk("bp_rdata", rsp_rdata, bufv);
      chk("bp_start", src_start, 0);
      chk("bp_ready", req_ready, 1);
      return;
    end
`endif
    @(negedge clk);
    chk("iss_start", src_start, 1);
    chk("iss_write", src_write, wr);
    chk("iss_steps", src_num_steps, steps);
    chk("iss_value", src_value, wd);
    chk("iss_ready", req_ready, 0);
    chk("iss_rsp", rsp_valid, 0);
    src_last_step = 1'b1;  // must be ignored during ISSUE
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("wait_start", src_start, 1);
      chk("wait_steps", src_num_steps, steps);
      chk("wait_rsp", rsp_valid, 0);
      src_last_step = 1'b0;
    end
    @(negedge clk);
    chk("wait_start_last", src_start, 1);
    src_last_step = 1'b1;
    bufv          = 8'($urandom);
    src_buffer    = bufv;
    @(negedge clk);
    src_last_step = 1'b0;
    chk("drain_start", src_start, 0);
    chk("drain_write", src_write, 0);
    chk("drain_rsp", rsp_valid, 0);
    chk("drain_ready", req_ready, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_error", rsp_error, 0);
    chk("rsp_rdata", rsp_rdata, wr ? wd : bufv);
    chk("rsp_ready", req_ready, 1);
    chk("rsp_start", src_start, 0);
    cursor = addr;
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    src_last_step = 1'b0;
    src_buffer    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_start", src_start, 0);
    chk("rst_write", src_write, 0);
    chk("rst_steps", src_num_steps, 0);
    chk("rst_value", src_value, 0);

    // Long controller wait, then wrap-around from the last slot.
    run_req(1'b0, 5, 8'h00, 40, 1'b0);
    run_req(1'b1, 11, 8'h3C, 2, 1'b0);
    run_req(1'b1, 0, 8'hA5, 0, 1'b0);
    // Same slot twice: zero steps.
    run_req(1'b0, 3, 8'h00, 1, 1'b0);
    run_req(1'b0, 3, 8'h00, 2, 1'b0);
    // Out of range, including the first illegal slot; cursor must survive.
    run_req(1'b0, 13, 8'h11, 0, 1'b0);
    run_req(1'b1, 12, 8'h22, 0, 1'b0);
    run_req(1'b0, 15, 8'h33, 0, 1'b0);
    run_req(1'b0, 7, 8'h00, 1, 1'b0);

    // Reset while waiting for lastStep.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd9;
    req_wdata = 8'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rw_iss_start", src_start, 1);
    src_last_step = 1'b0;
    @(negedge clk);
    chk("rw_wait_start", src_start, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_start", src_start, 0);
    chk("rw_ready", req_ready, 1);
    chk("rw_rsp", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_rsp_after", rsp_valid, 0);
    chk("rw_start_after", src_start, 0);
    cursor = 0;
    run_req(1'b0, 4, 8'h00, 0, 1'b0);

    // Back-to-back with req_valid held high.
    run_req(1'b0, 10, 8'h00, 1, 1'b1);
    run_req(1'b1, 2, 8'h5A, 0, 1'b1);
    run_req(1'b0, 6, 8'h00, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_req(1'($urandom), int'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
